id_ex_alu_issue: RTL and testbench
==================================

ID_EX_ALU_ISSUE -- requirements
Module: id_ex_alu_issue

Interface
REQ-001 Parameter XLEN, default 64, operand/result width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  decode stage holds a real instruction.
REQ-005 stall  input  1  hold the EX-stage register contents.
REQ-006 flush  input  1  replace the next EX-stage contents with a bubble.
REQ-007 id_alu_op  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 I-type arith.
REQ-008 id_funct3  input  3  instruction funct3.
REQ-009 id_funct7_5  input  1  instruction bit 30.
REQ-010 id_alu_src  input  1  1 selects the immediate for operand B.
REQ-011 id_rs1_data, id_rs2_data, id_imm  input  XLEN each  register-file reads and sign-extended immediate.
REQ-012 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-013 id_reg_write  input  1  instruction writes rd.
REQ-014 exmem_reg_write  input  1  EX/MEM-stage write enable.
REQ-015 exmem_rd  input  5  EX/MEM-stage destination.
REQ-016 exmem_result  input  XLEN  EX/MEM-stage ALU result.
REQ-017 memwb_reg_write  input  1  MEM/WB-stage write enable.
REQ-018 memwb_rd  input  5  MEM/WB-stage destination.
REQ-019 memwb_result  input  XLEN  MEM/WB-stage writeback value.
REQ-020 alu_a, alu_b  output  XLEN each  ALU operands.
REQ-021 alu_operation  output  4  ALU code: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLL 1000.
REQ-022 ex_valid, ex_reg_write, illegal_op  output  1 each  EX-stage status.
REQ-023 ex_rd  output  5  EX-stage destination.
REQ-024 ex_store_data  output  XLEN  forwarded rs2 value.

Function
REQ-025 On each rising edge with stall=0 and flush=0: all id_* fields are registered, and ex_valid <= id_valid.
REQ-026 With stall=1 and flush=0: every EX register holds its value.
REQ-027 flush=1 overrides stall=1: the EX register loads a bubble.
- Bubble contents: valid=0, reg_write=0, rs1=rs2=rd=0, data=0, imm=0, alu_op=00.
REQ-028 id_valid=0 is registered as a bubble.
REQ-029 alu_operation decode is combinational from the registered fields.
- alu_op 00 -> ADD; alu_op 01 -> SUB.
REQ-030 alu_op 10 (R-type) decode:
- funct3 000 -> ADD if funct7_5=0, SUB if funct7_5=1.
- funct3 111 -> AND; 110 -> OR; 001 -> SLL.
REQ-031 alu_op 11 (I-type arith) decode:
- funct3 000 -> ADD; 111 -> AND; 110 -> OR; 001 -> SLL.
REQ-032 Any other combination drives alu_operation=0010 (ADD) and illegal_op=ex_valid; otherwise illegal_op=0.
REQ-033 Forwarded rs1 value, selected in priority order:
- exmem_result if exmem_reg_write=1, exmem_rd!=0 and exmem_rd==ex rs1;
- else memwb_result on the same conditions against memwb_rd;
- else the registered rs1_data.
REQ-034 The forwarded rs2 value uses the same priority against ex rs2; ex_store_data equals the forwarded rs2 value.
REQ-035 alu_a = forwarded rs1.
REQ-036 alu_b = forwarded rs2 when alu_src=0.
- alu_src=1 and decoded SLL: alu_b = zero-extended imm[5:0].
- alu_src=1 otherwise: alu_b = imm.
REQ-037 Register x0 is never forwarded, so a bubble yields alu_a=alu_b=0 and alu_operation=ADD.
REQ-038 The EX stage adds zero cycles of latency beyond the single ID->EX register stage.

Reset
REQ-039 reset=1 at a rising edge loads the bubble state of REQ-027.
- After reset: ex_valid=0, ex_reg_write=0, ex_rd=0, illegal_op=0, alu_a=alu_b=0, alu_operation=0010.
REQ-040 reset has priority over flush and stall.
REQ-041 An instruction captured in the same cycle as reset is discarded.

Verification
REQ-042 R-type add: funct3=000, f7_5=0, rs1_data=5, rs2_data=7 -> next cycle alu_operation=0010, alu_a=5, alu_b=7, ex_valid=1.
REQ-043 slli: alu_op=11, funct3=001, imm=0x43 -> alu_operation=1000, alu_b=3.
REQ-044 Forwarding priority: ex rs1=4, exmem_rd=4 with result 0xAA, memwb_rd=4 with result 0xBB -> alu_a=0xAA; clear exmem_reg_write -> alu_a=0xBB; set rd=0 -> no forwarding.
REQ-045 Stall and flush: stall=1 for 3 cycles -> outputs unchanged; stall=1 with flush=1 -> ex_valid=0, ex_reg_write=0.
REQ-046 Illegal decode: alu_op=10, funct3=010 -> illegal_op=1, alu_operation=0010.
REQ-047 Reset mid-stream: assert reset while ex_valid=1 -> next cycle all outputs match the REQ-039 reset values.

Source files
------------

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX pipeline register with ALU control decode and EX-stage operand forwarding.
module id_ex_alu_issue #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      id_alu_op,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            id_alu_src,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_reg_write,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_operation,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            illegal_op,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_store_data
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  logic            r_valid, r_reg_write, r_funct7_5, r_alu_src;
  logic [1:0]      r_alu_op;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0] r_rs1_data, r_rs2_data, r_imm;
  logic [3:0]      w_arith_op;
  logic            w_arith_ok;
  logic [XLEN-1:0] w_fwd1, w_fwd2;
  // A decode-stage bubble is stored as the same all-zero state as reset or flush.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !id_valid)) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_op    <= 2'b00;
      r_funct3    <= 3'b000;
      r_funct7_5  <= 1'b0;
      r_alu_src   <= 1'b0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
    end else if (!stall) begin
      r_valid     <= 1'b1;
      r_reg_write <= id_reg_write;
      r_alu_op    <= id_alu_op;
      r_funct3    <= id_funct3;
      r_funct7_5  <= id_funct7_5;
      r_alu_src   <= id_alu_src;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
    end
  end
  always_comb begin
    w_arith_ok = (r_funct3 == 3'b000) || (r_funct3 == 3'b111) || (r_funct3 == 3'b110) || (r_funct3 == 3'b001);
    w_arith_op = (r_funct3 == 3'b000) ? ((r_funct7_5 && !r_alu_op[0]) ? OP_SUB : OP_ADD) :
                 (r_funct3 == 3'b111) ? OP_AND :
                 (r_funct3 == 3'b110) ? OP_OR  :
                 (r_funct3 == 3'b001) ? OP_SLL : OP_ADD;
    alu_operation = r_alu_op[1] ? w_arith_op : (r_alu_op[0] ? OP_SUB : OP_ADD);
    illegal_op = r_valid && r_alu_op[1] && !w_arith_ok;
    w_fwd1 = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r_rs1) ? exmem_result :
             (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r_rs1) ? memwb_result : r_rs1_data;
    w_fwd2 = (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r_rs2) ? exmem_result :
             (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r_rs2) ? memwb_result : r_rs2_data;
    alu_a = w_fwd1;
    alu_b = !r_alu_src ? w_fwd2 : (alu_operation == OP_SLL) ? {{(XLEN-6){1'b0}}, r_imm[5:0]} : r_imm;
    ex_store_data = w_fwd2;
  end
  assign ex_valid     = r_valid;
  assign ex_reg_write = r_reg_write;
  assign ex_rd        = r_rd;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb_id_ex_alu_issue: directed and randomized checks of id_ex_alu_issue against a behavioural model.
module tb_id_ex_alu_issue;
  localparam int XLEN = 64;
  logic            clk = 1'b0;
  logic            reset, id_valid, stall, flush, id_funct7_5, id_alu_src, id_reg_write;
  logic [1:0]      id_alu_op;
  logic [2:0]      id_funct3;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
  logic [4:0]      id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic            exmem_reg_write, memwb_reg_write;
  logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]      alu_operation;
  logic            ex_valid, ex_reg_write, illegal_op;
  logic [4:0]      ex_rd;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    bit            valid, rw, f7, src;
    bit [1:0]      op;
    bit [2:0]      f3;
    bit [4:0]      rs1, rs2, rd;
    bit [XLEN-1:0] d1, d2, imm;
  } ex_t;
  ex_t m;
  id_ex_alu_issue #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_alu_src(id_alu_src),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .illegal_op(illegal_op), .ex_rd(ex_rd), .ex_store_data(ex_store_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic ex_t bubble();
    ex_t b;
    b = '{default: 0};
    return b;
  endfunction
  function automatic logic [XLEN-1:0] fwd(input bit [4:0] idx, input bit [XLEN-1:0] regval);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
    return regval;
  endfunction
  task automatic check_all();
    logic [3:0] eop;
    bit bad;
    logic [XLEN-1:0] eb;
    bad = 0;
    case (m.op)
      2'd0: eop = 4'b0010;
      2'd1: eop = 4'b0110;
      default:
        case (m.f3)
          3'd0: eop = (m.op == 2'd2 && m.f7) ? 4'b0110 : 4'b0010;
          3'd7: eop = 4'b0000;
          3'd6: eop = 4'b0001;
          3'd1: eop = 4'b1000;
          default: begin eop = 4'b0010; bad = 1; end
        endcase
    endcase
    eb = !m.src ? fwd(m.rs2, m.d2) : (eop == 4'b1000) ? XLEN'(m.imm % 64) : m.imm;
    chk("alu_operation", alu_operation, eop);
    chk("illegal_op", illegal_op, bad && m.valid);
    chk("alu_a", alu_a, fwd(m.rs1, m.d1));
    chk("alu_b", alu_b, eb);
    chk("ex_store_data", ex_store_data, fwd(m.rs2, m.d2));
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_rd", ex_rd, m.rd);
  endtask
  task automatic step();
    @(posedge clk);
    if (reset || flush) m = bubble();
    else if (!stall) begin
      if (!id_valid) m = bubble();
      else m = '{valid: 1, rw: id_reg_write, f7: id_funct7_5, src: id_alu_src, op: id_alu_op, f3: id_funct3,
                 rs1: id_rs1, rs2: id_rs2, rd: id_rd, d1: id_rs1_data, d2: id_rs2_data, imm: id_imm};
    end
    #1;
    check_all();
  endtask
  task automatic instr(input bit [1:0] op, input bit [2:0] f3, input bit f7, input bit src,
                       input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                       input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd);
    id_valid = 1; id_reg_write = 1; id_alu_op = op; id_funct3 = f3; id_funct7_5 = f7; id_alu_src = src;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, " ex_valid"}, ex_valid, 0);
    chk({tag, " ex_reg_write"}, ex_reg_write, 0);
    chk({tag, " ex_rd"}, ex_rd, 0);
    chk({tag, " illegal_op"}, illegal_op, 0);
    chk({tag, " alu_a"}, alu_a, 0);
    chk({tag, " alu_b"}, alu_b, 0);
    chk({tag, " alu_operation"}, alu_operation, 4'b0010);
  endtask
  initial begin
    m = bubble();
    reset = 1; stall = 0; flush = 0;
    instr(2, 0, 0, 0, 64'h99, 64'h77, 64'h5, 1, 2, 3);
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    step(); step();
    reset_vals("rst");
    reset = 0;
    instr(2, 0, 0, 0, 64'd5, 64'd7, 64'h0, 1, 2, 3);
    step();
    chk("add op", alu_operation, 4'b0010);
    chk("add a", alu_a, 5);
    chk("add b", alu_b, 7);
    chk("add valid", ex_valid, 1);
    instr(3, 1, 0, 1, 64'd9, 64'd0, 64'h43, 1, 0, 3);
    step();
    chk("slli op", alu_operation, 4'b1000);
    chk("slli b", alu_b, 3);
    instr(2, 7, 0, 0, 64'h11, 64'h22, 64'h0, 4, 6, 7);
    step();
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 64'hAA;
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 64'hBB;
    #1 chk("fwd exmem", alu_a, 64'hAA);
    exmem_reg_write = 0;
    #1 chk("fwd memwb", alu_a, 64'hBB);
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    #1 chk("fwd x0", alu_a, 64'h11);
    exmem_reg_write = 0; memwb_reg_write = 0;
    instr(2, 0, 0, 0, 64'h21, 64'h42, 64'h0, 1, 2, 5);
    step();
    stall = 1;
    instr(3, 6, 1, 1, 64'h1234, 64'h5678, 64'h9, 8, 9, 10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall a", alu_a, 64'h21);
      chk("stall b", alu_b, 64'h42);
      chk("stall rd", ex_rd, 5);
      chk("stall valid", ex_valid, 1);
    end
    flush = 1;
    step();
    chk("flush valid", ex_valid, 0);
    chk("flush rw", ex_reg_write, 0);
    stall = 0; flush = 0;
    instr(2, 2, 0, 0, 64'h3, 64'h4, 64'h0, 1, 2, 3);
    step();
    chk("illegal flag", illegal_op, 1);
    chk("illegal op", alu_operation, 4'b0010);
    instr(1, 0, 0, 0, 64'h8, 64'h4, 64'h0, 1, 2, 3);
    step();
    chk("pre-reset valid", ex_valid, 1);
    reset = 1;
    step();
    reset_vals("midrst");
    reset = 0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(49) == 0);
      flush = ($urandom_range(9) == 0);
      stall = ($urandom_range(4) == 0);
      instr(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom));
      id_valid = ($urandom_range(3) != 0);
      id_reg_write = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(3)); exmem_result = {$urandom, $urandom};
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(3)); memwb_result = {$urandom, $urandom};
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
